// File: rtl/weight_pkg.sv
// Shared constants and encodings for the weight-buffer write path.
package weight_pkg;

    localparam int K3_BYTES   = 9;
    localparam int K1_BYTES   = 1;
    localparam int ADDR_W_DEF = 8;
    localparam int CH_W_DEF   = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    typedef enum logic {
        CONV_3X3 = 1'b0,
        CONV_1X1 = 1'b1
    } conv_t;

endpackage

// File: rtl/weight_wr_ctrl.sv
// Write-side controller for the per-channel weight buffer: counts streamed bytes per
// kernel and strobes one write per complete kernel, address-major / channel-minor.
module weight_wr_ctrl
    import weight_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int CH_W     = CH_W_DEF,
    parameter int K3_BYTES = weight_pkg::K3_BYTES
) (
    input  logic              sclk,
    input  logic              s_rst,
    input  logic              load_start,
    input  logic              cfg_conv_type,
    input  logic [ADDR_W-1:0] cfg_kernel_num_m1,
    input  logic [CH_W-1:0]   cfg_ch_num_m1,
    input  logic              weight_data_in_vld,
    output logic              weight_ready,
    output logic              conv_type,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [CH_W-1:0]   ch_cnt,
    output logic              load_busy,
    output logic              load_done,
    output logic              frame_err
);

    localparam int BCNT_W = $clog2(K3_BYTES);

    state_t              state_q, state_d;
    conv_t               conv_q;
    logic [ADDR_W-1:0]   kern_m1_q;
    logic [CH_W-1:0]     ch_m1_q;
    logic [BCNT_W-1:0]   byte_cnt_q;
    logic [ADDR_W-1:0]   addr_ptr_q;
    logic [CH_W-1:0]     ch_ptr_q;

    logic in_load;
    logic last_byte;
    logic final_kernel;
    logic kernel_gap;

    assign in_load      = (state_q == ST_LOAD);
    assign last_byte    = in_load && weight_data_in_vld &&
                          ((conv_q == CONV_1X1) ? (byte_cnt_q == BCNT_W'(K1_BYTES - 1))
                                                : (byte_cnt_q == BCNT_W'(K3_BYTES - 1)));
    assign final_kernel = last_byte && (addr_ptr_q == kern_m1_q) && (ch_ptr_q == ch_m1_q);
    // The buffer reloads its shift register on a vld gap, so a partial 3x3 kernel is lost.
    assign kernel_gap   = in_load && !weight_data_in_vld && (conv_q == CONV_3X3) &&
                          (byte_cnt_q != '0);

    // NOTE: reset is synchronous, so it lives inside the clocked branch; state uses <= only.
    always_ff @(posedge sclk) begin
        if (s_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (load_start)   state_d = ST_LOAD;
            ST_LOAD: if (final_kernel) state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load_busy    = in_load;
        weight_ready = in_load;
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            conv_q     <= CONV_3X3;
            kern_m1_q  <= '0;
            ch_m1_q    <= '0;
            byte_cnt_q <= '0;
            addr_ptr_q <= '0;
            ch_ptr_q   <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            ch_cnt     <= '0;
            load_done  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            load_done <= 1'b0;
            if (state_q == ST_IDLE && load_start) begin
                conv_q     <= conv_t'(cfg_conv_type);
                kern_m1_q  <= cfg_kernel_num_m1;
                ch_m1_q    <= cfg_ch_num_m1;
                byte_cnt_q <= '0;
                addr_ptr_q <= '0;
                ch_ptr_q   <= '0;
                frame_err  <= 1'b0;
            end else if (last_byte) begin
                // Strobe one cycle late so wr_en lines up with the buffer's registered data.
                wr_en      <= 1'b1;
                wr_addr    <= addr_ptr_q;
                ch_cnt     <= ch_ptr_q;
                load_done  <= final_kernel;
                byte_cnt_q <= '0;
                if (!final_kernel) begin
                    if (ch_ptr_q == ch_m1_q) begin
                        ch_ptr_q   <= '0;
                        addr_ptr_q <= addr_ptr_q + ADDR_W'(1);
                    end else begin
                        ch_ptr_q   <= ch_ptr_q + CH_W'(1);
                    end
                end
            end else if (in_load && weight_data_in_vld) begin
                byte_cnt_q <= byte_cnt_q + BCNT_W'(1);
            end else if (kernel_gap) begin
                frame_err  <= 1'b1;
                byte_cnt_q <= '0;
            end
        end
    end

    assign conv_type = conv_q;

endmodule

// File: doc/weight_wr_ctrl.md
Name: weight_wr_ctrl

Overview:
Write-side controller for the per-channel 3x3/1x1 weight buffer. It accepts a configured load request and a gapless byte stream, counts bytes per kernel, and drives the buffer's wr_en, wr_addr, ch_cnt and conv_type. Each write lands exactly when the buffer's internal shift register holds a complete kernel. It sits between the DMA/AXI-stream weight source and the weight buffer.

Parameters:
ADDR_W, 8, buffer address width (kernel slots per channel = 2^ADDR_W)
CH_W, 3, channel-select width (8 channel RAMs)
K3_BYTES, 9, bytes per 3x3 kernel

Ports:
sclk  in  1  system clock
s_rst  in  1  synchronous reset, active-high
load_start  in  1  single-cycle pulse; latches cfg_* and begins a load
cfg_conv_type  in  1  0 = 3x3 (9 bytes/kernel), 1 = 1x1 (1 byte/kernel)
cfg_kernel_num_m1  in  ADDR_W  number of kernel slots minus 1
cfg_ch_num_m1  in  CH_W  number of input channels minus 1
weight_data_in_vld  in  1  byte valid; also forwarded untouched to the buffer
weight_ready  out  1  high while in LOAD; source may present bytes only while it is high
conv_type  out  1  latched cfg_conv_type, held constant for the whole load
wr_en  out  1  buffer write strobe
wr_addr  out  ADDR_W  buffer write address
ch_cnt  out  CH_W  target channel RAM
load_busy  out  1  state == LOAD
load_done  out  1  single-cycle pulse with the final wr_en
frame_err  out  1  sticky; a vld gap occurred inside a 3x3 kernel

Behaviour:
- Reset: state IDLE. wr_en, load_busy, load_done, frame_err, weight_ready are 0. wr_addr, ch_cnt and conv_type are 0. All counters are 0.
- States:
  - IDLE: on load_start, latch cfg, clear frame_err, zero byte_cnt/ch_ptr/addr_ptr, go to LOAD.
  - LOAD: go to IDLE on the edge that accepts the final byte.
  - There is no separate DONE state.
- Loop order: addr outer, channel inner. Sequence is (a0,c0), (a0,c1) … (a0,cN), (a1,c0) …
- Byte counting (LOAD only): byte_cnt increments on each vld. The last byte of a kernel is byte_cnt == K3_BYTES-1 (3x3) or every vld (1x1).
- Write strobe, 1-cycle latency:
  - On the edge that samples the last byte, register wr_en <= 1, wr_addr <= addr_ptr, ch_cnt <= ch_ptr.
  - In the same edge, advance the pointers: ch_ptr wraps at cfg_ch_num_m1 and then addr_ptr increments.
  - This aligns wr_en with the buffer's registered wr_data.
  - wr_en is high for exactly one cycle per kernel. Back-to-back kernels give consecutive wr_en cycles (1x1 case).
- wr_addr and ch_cnt hold their last value between strobes.
- Final kernel (addr_ptr == cfg_kernel_num_m1 and ch_ptr == cfg_ch_num_m1):
  - load_done pulses in the same cycle as its wr_en.
  - load_busy and weight_ready drop in that same cycle.
- Gap rule (3x3 only): the buffer reloads its shift register when vld is low, so a partial kernel is lost.
  - If vld is low while 0 < byte_cnt < K3_BYTES, set frame_err, reset byte_cnt to 0, and issue no write.
  - Pointers are not advanced, so the kernel is retried from its first byte.
  - Gaps with byte_cnt == 0 are legal.
- vld in IDLE is ignored: no count, no write.
- load_start while in LOAD is ignored and the cfg is not re-latched.
- load_start in the same cycle as load_done: the new load is accepted on the next cycle, not this one.
- s_rst mid-load: immediate return to reset values. Any partially written buffer contents are left as-is.
- Max load is 2^ADDR_W × 2^CH_W kernels. addr_ptr never wraps past cfg_kernel_num_m1.

Decomposition:
- Shared package (weight_pkg): K3_BYTES, K1_BYTES = 1, ADDR_W/CH_W defaults, the state encoding (IDLE, LOAD), and the conv_type encodings (CONV_3X3 = 0, CONV_1X1 = 1).
- Single module; no sub-module is warranted. The byte counter and the channel/address pointer pair are a few lines each.

Test Plan:
- 3x3, cfg_ch_num_m1 = 1, cfg_kernel_num_m1 = 1, 36 gapless bytes → four wr_en pulses, each one cycle after bytes 9/18/27/36, with (addr,ch) = (0,0), (0,1), (1,0), (1,1). load_done coincides with the 4th pulse; frame_err stays 0.
- 1x1, ch_m1 = 7, kernel_m1 = 3, 32 back-to-back bytes → 32 consecutive wr_en cycles. ch_cnt cycles 0..7 and wr_addr steps 0..3. load_done is on cycle 32 after the first byte.
- 3x3, vld dropped after byte 5 of kernel (0,0), then 9 clean bytes → frame_err = 1. The first write is (0,0) and occurs after the 9 clean bytes; no earlier wr_en.
- load_start pulsed mid-load with different cfg → ignored. The write sequence and count match the original cfg.
- s_rst asserted after 3 of 4 writes → next cycle all outputs are 0 and state is IDLE. A new load_start then restarts at (0,0).
- Full size, 3x3, kernel_m1 = 255, ch_m1 = 7 → 2048 writes. The last write is (255,7) with load_done, and there is no wr_en afterwards even with extra vld bytes.
